control_unit: RTL and testbench

- Instruction-decode block of the KGP-RISC processor.
- Takes the 32-bit fetched instruction and the four ALU status flags.
- Produces all datapath controls: register-file and data-memory write enables, write-back and address mux selects, ALU operation and shift amount, and the PC next-address control.
- Decode is combinational. Outputs are registered, giving 1-cycle latency.

---
 rtl/kgp_risc_pkg.sv | 56 +++++
 rtl/control_decoder.sv | 111 +++++++++++
 rtl/control_unit.sv | 87 ++++++++
 tb/tb_control_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/kgp_risc_pkg.sv
// Shared encodings for the KGP-RISC decode path: opcodes, R-type funct codes,
// ALU operation codes, PC-control codes and write-back mux codes.
package kgp_risc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_COMPI = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_B     = 6'b010000;
    localparam logic [5:0] OP_BR    = 6'b010001;
    localparam logic [5:0] OP_BLTZ  = 6'b010010;
    localparam logic [5:0] OP_BZ    = 6'b010011;
    localparam logic [5:0] OP_BNZ   = 6'b010100;
    localparam logic [5:0] OP_BCY   = 6'b010101;
    localparam logic [5:0] OP_BNCY  = 6'b010110;
    localparam logic [5:0] OP_BO    = 6'b010111;
    localparam logic [5:0] OP_BNO   = 6'b011000;
    localparam logic [5:0] OP_BL    = 6'b011010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_COMP  = 6'b011000;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_SHLL  = 6'b000000;
    localparam logic [5:0] FN_SHRL  = 6'b000010;
    localparam logic [5:0] FN_SHRA  = 6'b000011;
    localparam logic [5:0] FN_SHLLV = 6'b000100;
    localparam logic [5:0] FN_SHRLV = 6'b000110;
    localparam logic [5:0] FN_SHRAV = 6'b000111;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_COMP = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_XOR  = 4'h3;
    localparam logic [3:0] ALU_SLL  = 4'h4;
    localparam logic [3:0] ALU_SRL  = 4'h5;
    localparam logic [3:0] ALU_SRA  = 4'h6;
    localparam logic [3:0] ALU_SLLV = 4'h7;
    localparam logic [3:0] ALU_SRLV = 4'h8;
    localparam logic [3:0] ALU_SRAV = 4'h9;
    localparam logic [3:0] ALU_NOP  = 4'hF;

    localparam logic [3:0] PC_SEQ = 4'd0;
    localparam logic [3:0] PC_IMM = 4'd1;
    localparam logic [3:0] PC_REG = 4'd2;

    localparam logic [1:0] DMUX_ALU = 2'b00;
    localparam logic [1:0] DMUX_MEM = 2'b01;
    localparam logic [1:0] DMUX_PC4 = 2'b10;

    function automatic logic is_imm_shift(input logic [3:0] alu);
        return (alu == ALU_SLL) || (alu == ALU_SRL) || (alu == ALU_SRA);
    endfunction

endpackage

// File: rtl/control_decoder.sv
// Purely combinational instruction decode; every unrecognised encoding falls
// through to the NOP control word.
module control_decoder
    import kgp_risc_pkg::*;
(
    input  logic [31:0] instruction,
    input  logic        z_flag,
    input  logic        carry_flag,
    input  logic        sign_flag,
    input  logic        overflow_flag,
    output logic        data_mem_wren,
    output logic        reg_file_wren,
    output logic [1:0]  dmux_select,
    output logic        rmux_select,
    output logic        alu_mux_select,
    output logic [3:0]  alu_control,
    output logic [4:0]  alu_shamt,
    output logic        radd0_select,
    output logic [3:0]  pc_control
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [3:0] rtype_alu;
    logic       rtype_valid;
    logic       branch_taken;

    assign op    = instruction[31:26];
    assign funct = instruction[5:0];

    always_comb begin
        rtype_valid = 1'b1;
        rtype_alu   = ALU_NOP;
        case (funct)
            FN_ADD:   rtype_alu = ALU_ADD;
            FN_COMP:  rtype_alu = ALU_COMP;
            FN_AND:   rtype_alu = ALU_AND;
            FN_XOR:   rtype_alu = ALU_XOR;
            FN_SHLL:  rtype_alu = ALU_SLL;
            FN_SHRL:  rtype_alu = ALU_SRL;
            FN_SHRA:  rtype_alu = ALU_SRA;
            FN_SHLLV: rtype_alu = ALU_SLLV;
            FN_SHRLV: rtype_alu = ALU_SRLV;
            FN_SHRAV: rtype_alu = ALU_SRAV;
            default:  rtype_valid = 1'b0;
        endcase
        // An all-zero word would otherwise decode as "shll r0,r0,0".
        if (instruction == 32'h0) begin
            rtype_valid = 1'b0;
        end
    end

    always_comb begin
        branch_taken = 1'b0;
        case (op)
            OP_B, OP_BR, OP_BL: branch_taken = 1'b1;
            OP_BLTZ: branch_taken = sign_flag;
            OP_BZ:   branch_taken = z_flag;
            OP_BNZ:  branch_taken = ~z_flag;
            OP_BCY:  branch_taken = carry_flag;
            OP_BNCY: branch_taken = ~carry_flag;
            OP_BO:   branch_taken = overflow_flag;
            OP_BNO:  branch_taken = ~overflow_flag;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        data_mem_wren  = 1'b0;
        reg_file_wren  = 1'b0;
        dmux_select    = DMUX_ALU;
        rmux_select    = 1'b0;
        alu_mux_select = 1'b0;
        alu_control    = ALU_NOP;
        alu_shamt      = 5'd0;
        radd0_select   = 1'b0;
        pc_control     = PC_SEQ;
        case (op)
            OP_RTYPE: begin
                if (rtype_valid) begin
                    reg_file_wren = 1'b1;
                    alu_control   = rtype_alu;
                    if (is_imm_shift(rtype_alu)) begin
                        radd0_select = 1'b1;
                        alu_shamt    = instruction[10:6];
                    end
                end
            end
            OP_ADDI, OP_COMPI, OP_LW, OP_SW: begin
                rmux_select    = 1'b1;
                alu_mux_select = 1'b1;
                alu_control    = (op == OP_COMPI) ? ALU_COMP : ALU_ADD;
                reg_file_wren  = (op != OP_SW);
                data_mem_wren  = (op == OP_SW);
                dmux_select    = (op == OP_LW) ? DMUX_MEM : DMUX_ALU;
            end
            OP_B, OP_BR, OP_BLTZ, OP_BZ, OP_BNZ, OP_BCY, OP_BNCY, OP_BO, OP_BNO: begin
                if (branch_taken) begin
                    pc_control = (op == OP_BR) ? PC_REG : PC_IMM;
                end
            end
            OP_BL: begin
                pc_control    = PC_IMM;
                reg_file_wren = 1'b1;
                dmux_select   = DMUX_PC4;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// KGP-RISC control unit: combinational decode followed by one register stage
// that returns to the NOP control word on reset.
module control_unit
    import kgp_risc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        z_flag,
    input  logic        carry_flag,
    input  logic        sign_flag,
    input  logic        overflow_flag,
    output logic        data_mem_wren,
    output logic        reg_file_wren,
    output logic        reg_file_dmux_select_1,
    output logic        reg_file_dmux_select_0,
    output logic        reg_file_rmux_select,
    output logic        alu_mux_select,
    output logic [3:0]  alu_control,
    output logic [4:0]  alu_shamt,
    output logic        reg_file_radd0_select,
    output logic [3:0]  pc_control
);

    logic       data_mem_wren_d,  data_mem_wren_q;
    logic       reg_file_wren_d,  reg_file_wren_q;
    logic [1:0] dmux_select_d,    dmux_select_q;
    logic       rmux_select_d,    rmux_select_q;
    logic       alu_mux_select_d, alu_mux_select_q;
    logic [3:0] alu_control_d,    alu_control_q;
    logic [4:0] alu_shamt_d,      alu_shamt_q;
    logic       radd0_select_d,   radd0_select_q;
    logic [3:0] pc_control_d,     pc_control_q;

    control_decoder u_decoder (
        .instruction    (instruction),
        .z_flag         (z_flag),
        .carry_flag     (carry_flag),
        .sign_flag      (sign_flag),
        .overflow_flag  (overflow_flag),
        .data_mem_wren  (data_mem_wren_d),
        .reg_file_wren  (reg_file_wren_d),
        .dmux_select    (dmux_select_d),
        .rmux_select    (rmux_select_d),
        .alu_mux_select (alu_mux_select_d),
        .alu_control    (alu_control_d),
        .alu_shamt      (alu_shamt_d),
        .radd0_select   (radd0_select_d),
        .pc_control     (pc_control_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_mem_wren_q  <= 1'b0;
            reg_file_wren_q  <= 1'b0;
            dmux_select_q    <= DMUX_ALU;
            rmux_select_q    <= 1'b0;
            alu_mux_select_q <= 1'b0;
            alu_control_q    <= ALU_NOP;
            alu_shamt_q      <= 5'd0;
            radd0_select_q   <= 1'b0;
            pc_control_q     <= PC_SEQ;
        end else begin
            data_mem_wren_q  <= data_mem_wren_d;
            reg_file_wren_q  <= reg_file_wren_d;
            dmux_select_q    <= dmux_select_d;
            rmux_select_q    <= rmux_select_d;
            alu_mux_select_q <= alu_mux_select_d;
            alu_control_q    <= alu_control_d;
            alu_shamt_q      <= alu_shamt_d;
            radd0_select_q   <= radd0_select_d;
            pc_control_q     <= pc_control_d;
        end
    end

    assign data_mem_wren          = data_mem_wren_q;
    assign reg_file_wren          = reg_file_wren_q;
    assign reg_file_dmux_select_1 = dmux_select_q[1];
    assign reg_file_dmux_select_0 = dmux_select_q[0];
    assign reg_file_rmux_select   = rmux_select_q;
    assign alu_mux_select         = alu_mux_select_q;
    assign alu_control            = alu_control_q;
    assign alu_shamt              = alu_shamt_q;
    assign reg_file_radd0_select  = radd0_select_q;
    assign pc_control             = pc_control_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed cases plus randomized
// instructions/flags against a table-driven behavioural model.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instruction = 32'h0;
    logic        z_flag = 1'b0, carry_flag = 1'b0, sign_flag = 1'b0, overflow_flag = 1'b0;
    logic        data_mem_wren, reg_file_wren;
    logic        reg_file_dmux_select_1, reg_file_dmux_select_0;
    logic        reg_file_rmux_select, alu_mux_select, reg_file_radd0_select;
    logic [3:0]  alu_control, pc_control;
    logic [4:0]  alu_shamt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk                    (clk),
        .rst                    (rst),
        .instruction            (instruction),
        .z_flag                 (z_flag),
        .carry_flag             (carry_flag),
        .sign_flag              (sign_flag),
        .overflow_flag          (overflow_flag),
        .data_mem_wren          (data_mem_wren),
        .reg_file_wren          (reg_file_wren),
        .reg_file_dmux_select_1 (reg_file_dmux_select_1),
        .reg_file_dmux_select_0 (reg_file_dmux_select_0),
        .reg_file_rmux_select   (reg_file_rmux_select),
        .alu_mux_select         (alu_mux_select),
        .alu_control            (alu_control),
        .alu_shamt              (alu_shamt),
        .reg_file_radd0_select  (reg_file_radd0_select),
        .pc_control             (pc_control)
    );

    // Observed control word: {dm_wren, rf_wren, dmux[1:0], rmux, alu_mux, alu[3:0], shamt[4:0], radd0, pc[3:0]}
    logic [19:0] out_word;
    assign out_word = {data_mem_wren, reg_file_wren, reg_file_dmux_select_1, reg_file_dmux_select_0,
                       reg_file_rmux_select, alu_mux_select, alu_control, alu_shamt,
                       reg_file_radd0_select, pc_control};

    localparam logic [19:0] NOP_WORD = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'hF, 5'd0, 1'b0, 4'd0};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: funct table position is the ALU code; branch opcodes
    // 16..24 index a list of taken-conditions.
    function automatic logic [19:0] model(input logic [31:0] ins, input logic z, input logic c,
                                          input logic s, input logic o);
        int fn_table[10] = '{32, 24, 36, 38, 0, 2, 3, 4, 6, 7};
        logic cond[9];
        int op, fn;
        logic dm, rw, rm, am, ra;
        logic [1:0] ds;
        logic [3:0] alu, pc;
        logic [4:0] sh;
        dm = 0; rw = 0; rm = 0; am = 0; ra = 0; ds = 0; alu = 4'd15; pc = 0; sh = 0;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        cond = '{1'b1, 1'b1, s, z, !z, c, !c, o, !o};
        if (ins != 0) begin
            if (op == 0) begin
                for (int i = 0; i < 10; i++) begin
                    if (fn_table[i] == fn) begin
                        rw = 1;
                        alu = 4'(i);
                        if (i >= 4 && i <= 6) begin
                            ra = 1;
                            sh = ins[10:6];
                        end
                    end
                end
            end else if (op == 8 || op == 9) begin
                rw = 1; rm = 1; am = 1; alu = 4'(op - 8);
            end else if (op == 35) begin
                rw = 1; rm = 1; am = 1; alu = 0; ds = 2'd1;
            end else if (op == 43) begin
                dm = 1; rm = 1; am = 1; alu = 0;
            end else if (op >= 16 && op <= 24) begin
                if (cond[op - 16]) pc = (op == 17) ? 4'd2 : 4'd1;
            end else if (op == 26) begin
                pc = 1; rw = 1; ds = 2'd2;
            end
        end
        return {dm, rw, ds, rm, am, alu, sh, ra, pc};
    endfunction

    task automatic apply(input string tag, input logic [31:0] ins, input logic [3:0] flags);
        logic [19:0] exp;
        @(negedge clk);
        instruction = ins;
        {z_flag, carry_flag, sign_flag, overflow_flag} = flags;
        exp = model(ins, flags[3], flags[2], flags[1], flags[0]);
        @(posedge clk);
        #1;
        $display("txn %-8s ins=%h zcso=%b out=%h exp=%h", tag, ins, flags, out_word, exp);
        check_eq(tag, 32'(out_word), 32'(exp));
        check_eq({tag, "_excl"}, 32'(data_mem_wren & reg_file_wren), 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        int valid_ops[13] = '{8, 9, 35, 43, 16, 17, 18, 19, 20, 21, 22, 23, 24};
        int fns[10] = '{32, 24, 36, 38, 0, 2, 3, 4, 6, 7};
        logic [31:0] r;
        int kind;
        r = $urandom;
        kind = $urandom_range(0, 11);
        if (kind <= 3) begin
            r[31:26] = 6'd0;
            r[5:0] = (kind == 3) ? 6'($urandom) : 6'(fns[$urandom_range(0, 9)]);
        end else if (kind <= 8) begin
            r[31:26] = 6'(valid_ops[$urandom_range(0, 12)]);
        end else if (kind == 9) begin
            r[31:26] = 6'd26;
        end else if (kind == 11) begin
            r = 32'h0;
        end
        return r;
    endfunction

    initial begin
        instruction = 32'h2149_0001;
        #1 rst = 1'b1;
        #1;
        $display("txn reset_async out=%h", out_word);
        check_eq("reset_async", 32'(out_word), 32'(NOP_WORD));
        repeat (2) @(posedge clk);
        #1;
        $display("txn reset_hold out=%h", out_word);
        check_eq("reset_hold", 32'(out_word), 32'(NOP_WORD));
        @(negedge clk);
        rst = 1'b0;
        apply("addi", 32'h2149_0001, 4'b0000);
        apply("add",  32'h016A_0020, 4'b0000);
        apply("comp", 32'h016A_0018, 4'b1111);
        apply("sw",   32'hAD6A_0002, 4'b0000);
        apply("lw",   32'h8D6A_0002, 4'b0000);
        apply("shll2", 32'h016A_0080, 4'b0000);
        apply("bnz_t", 32'h5000_0000, 4'b0000);
        apply("bnz_f", 32'h5000_0000, 4'b1000);
        apply("b_0",  32'h4000_0000, 4'b0000);
        apply("b_1",  32'h4000_0000, 4'b1111);
        apply("br",   32'h4440_0000, 4'b0101);
        apply("bl",   32'h6800_0000, 4'b0000);
        apply("zero", 32'h0000_0000, 4'b1111);
        apply("badfn", 32'h016A_0021, 4'b0000);
        apply("badop", 32'hFC00_0000, 4'b0000);
        apply("shra", 32'h016A_07C3, 4'b0000);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                @(negedge clk);
                instruction = rand_instr();
                rst = 1'b1;
                #1;
                $display("txn rst_mid ins=%h out=%h", instruction, out_word);
                check_eq("rst_mid", 32'(out_word), 32'(NOP_WORD));
                @(posedge clk);
                #1;
                check_eq("rst_mid_hold", 32'(out_word), 32'(NOP_WORD));
                @(negedge clk);
                rst = 1'b0;
            end
            apply("rand", rand_instr(), 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
